// File: rtl/jt1943_obj_pkg.sv
// Shared constants for the 1943 object (sprite) line buffer.
package jt1943_obj_pkg;

  localparam int LINE_W = 256;
  // Wide all-ones word; users slice it down to their pixel width.
  localparam logic [63:0] TRANSP_PXL = '1;

endpackage

// File: rtl/jt1943_objlinebuf_ram.sv
// 256-entry line RAM: write-only draw port plus a read/write port with registered read.
module jt1943_objlinebuf_ram
  import jt1943_obj_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [7:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rw_rd,
  input  logic          rw_we,
  input  logic [7:0]    rw_addr,
  input  logic [DW-1:0] rw_wdata,
  output logic [DW-1:0] rw_q
);

  logic [DW-1:0] mem [LINE_W];

  // The owner guarantees wr_en and rw_we never target the same RAM together.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rw_we) mem[rw_addr] <= rw_wdata;
    if (rw_rd) rw_q <= mem[rw_addr];
  end

endmodule

// File: rtl/jt1943_objlinebuf.sv
// Double-buffered sprite line buffer: one buffer is drawn while the other is
// read out (and cleared behind the read pointer) for display.
module jt1943_objlinebuf
  import jt1943_obj_pkg::*;
#(
  parameter int DW      = 8,
  parameter int PALW    = 4,
  parameter int OBJ_DLY = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen6,
  input  logic          LHBL,
  input  logic          flip,
  input  logic          line,
  input  logic          pxl_we,
  input  logic [8:0]    posx,
  input  logic [DW-1:0] new_pxl,
  output logic [DW-1:0] obj_pxl
);

  localparam logic [DW-1:0]   ONES = TRANSP_PXL[DW-1:0];
  localparam logic [PALW-1:0] TCOL = TRANSP_PXL[PALW-1:0];

  logic [7:0]    rdcnt;
  logic          rd_tick;
  logic          draw_we;
  logic          clr_pend;
  logic [7:0]    clr_addr;
  logic          clr_buf;
  logic          rd_valid;
  logic          rd_buf;
  logic [7:0]    rw_addr;
  logic [DW-1:0] q0, q1;
  logic [DW-1:0] rd_latch;
  logic [DW-1:0] dly [OBJ_DLY];

  assign rd_tick = cen6 & LHBL;
  assign draw_we = cen6 & pxl_we & ~posx[8] & (new_pxl[PALW-1:0] != TCOL);
  // Clear writes land on the cycle after a read tick, when no read can occur.
  assign rw_addr = clr_pend ? clr_addr : rdcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdcnt <= 8'd0;
    end else if (!LHBL) begin
      rdcnt <= flip ? 8'hFF : 8'h00;
    end else if (cen6) begin
      rdcnt <= flip ? rdcnt - 8'd1 : rdcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_pend <= 1'b0;
      clr_addr <= 8'd0;
      clr_buf  <= 1'b0;
      rd_valid <= 1'b0;
      rd_buf   <= 1'b0;
    end else begin
      clr_pend <= rd_tick;
      if (rd_tick) begin
        clr_addr <= rdcnt;
        clr_buf  <= ~line;
      end
      if (cen6) begin
        rd_valid <= LHBL;
        rd_buf   <= ~line;
      end
    end
  end

  jt1943_objlinebuf_ram #(.DW(DW)) u_buf0 (
    .clk      (clk),
    .wr_en    (draw_we & ~line),
    .wr_addr  (posx[7:0]),
    .wr_data  (new_pxl),
    .rw_rd    (rd_tick & line),
    .rw_we    (clr_pend & ~clr_buf),
    .rw_addr  (rw_addr),
    .rw_wdata (ONES),
    .rw_q     (q0)
  );

  jt1943_objlinebuf_ram #(.DW(DW)) u_buf1 (
    .clk      (clk),
    .wr_en    (draw_we & line),
    .wr_addr  (posx[7:0]),
    .wr_data  (new_pxl),
    .rw_rd    (rd_tick & ~line),
    .rw_we    (clr_pend & clr_buf),
    .rw_addr  (rw_addr),
    .rw_wdata (ONES),
    .rw_q     (q1)
  );

  // The RAM output register doubles as the read latch; blank ticks force it transparent.
  assign rd_latch = !rd_valid ? ONES : (rd_buf ? q1 : q0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBJ_DLY; i++) dly[i] <= ONES;
    end else if (cen6) begin
      dly[0] <= rd_latch;
      for (int i = 1; i < OBJ_DLY; i++) dly[i] <= dly[i-1];
    end
  end

  assign obj_pxl = dly[OBJ_DLY-1];

endmodule
